// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default program entry points and the reserved program-select code.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

    localparam int DEF_PROG1_ADDR = 0;
    localparam int DEF_PROG2_ADDR = 256;
    localparam int DEF_PROG3_ADDR = 512;

    localparam logic [1:0] PROGSEL_INVALID = 2'b11;

endpackage

// File: rtl/instr_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear wins over enable; once all-ones is reached the value holds.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count register: async reset, clear, then saturating increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Program counter / fetch sequencer. Selects the program entry point on
// Start, steps or branches the PC while running, and stops on the decoder's
// done-instruction acknowledge. Running/Done come straight from the state
// register so they never glitch.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int PROG1_ADDR = DEF_PROG1_ADDR,
    parameter int PROG2_ADDR = DEF_PROG2_ADDR,
    parameter int PROG3_ADDR = DEF_PROG3_ADDR,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       ProgSel,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Target,
    input  logic             Ack,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCt
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [PC_W-1:0] pc_next;
    logic            launch;
    logic            in_run;

    function automatic logic [PC_W-1:0] entry_addr(input logic [1:0] sel);
        case (sel)
            2'd0:    entry_addr = PC_W'(PROG1_ADDR);
            2'd1:    entry_addr = PC_W'(PROG2_ADDR);
            default: entry_addr = PC_W'(PROG3_ADDR);
        endcase
    endfunction

    // A program may only be launched from IDLE or HALT with a valid select
    assign launch = Start && (ProgSel != PROGSEL_INVALID) && (state != FS_RUN);
    assign in_run = (state == FS_RUN);

    // Next state and next PC; Ack beats a taken branch, which beats increment
    always_comb begin
        state_next = state;
        pc_next    = ProgCtr;
        case (state)
            FS_IDLE, FS_HALT: begin
                if (launch) begin
                    state_next = FS_RUN;
                    pc_next    = entry_addr(ProgSel);
                end
            end
            FS_RUN: begin
                if (Ack) begin
                    state_next = FS_HALT;
                end else if (BranchEn && Taken) begin
                    pc_next = Target;
                end else begin
                    pc_next = ProgCtr + PC_W'(1);
                end
            end
            default: begin
                state_next = FS_IDLE;
            end
        endcase
    end

    // State and PC registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= FS_IDLE;
            ProgCtr <= '0;
        end else begin
            state   <= state_next;
            ProgCtr <= pc_next;
        end
    end

    assign Running = (state == FS_RUN);
    assign Done    = (state == FS_HALT);

    // Counts every RUN edge (including the Ack edge); cleared on launch
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cycle_ctr (
        .clk  (Clk),
        .rst  (Reset),
        .clr  (launch),
        .en   (in_run),
        .count(CycleCt)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch. The driver applies one input vector per
// cycle and queues the hand-computed outputs expected after the next edge;
// the monitor pops and compares. A second instance with a 3-bit cycle
// counter shares the stimulus so counter saturation is reachable quickly.
module tb_instr_fetch;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [1:0] ProgSel = 2'd0;
    logic       BranchEn = 1'b0;
    logic       Taken = 1'b0;
    logic [9:0] Target = 10'd0;
    logic       Ack = 1'b0;

    logic [9:0]  ProgCtr;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCt;

    logic [9:0] pc_s;
    logic       run_s;
    logic       done_s;
    logic [2:0] cct_s;

    instr_fetch dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .Ack(Ack),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .CycleCt(CycleCt)
    );

    instr_fetch #(.CNT_W(3)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .Ack(Ack),
        .ProgCtr(pc_s), .Running(run_s), .Done(done_s), .CycleCt(cct_s)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          due;
        bit          which;
        logic [9:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cct;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    event  chk_ev;

    task automatic check_front();
        exp_t        e;
        string       nm;
        logic [9:0]  apc;
        logic        ar;
        logic        ad;
        logic [15:0] ac;
        e  = q.pop_front();
        nm = nq.pop_front();
        if (e.which) begin
            apc = pc_s; ar = run_s; ad = done_s; ac = {13'd0, cct_s};
        end else begin
            apc = ProgCtr; ar = Running; ad = Done; ac = CycleCt;
        end
        n_cmp++;
        if (apc !== e.pc || ar !== e.run || ad !== e.done || ac !== e.cct) begin
            n_bad++;
            $display("FAIL %s: got pc=%0d run=%0b done=%0b cyc=%0d, want pc=%0d run=%0b done=%0b cyc=%0d",
                     nm, apc, ar, ad, ac, e.pc, e.run, e.done, e.cct);
        end
    endtask

    // Monitor: compare everything due after this clock edge
    always @(posedge Clk) begin
        cyc++;
        #1;
        while (q.size() > 0 && q[0].due == cyc) check_front();
    end

    // Monitor: immediate (between-edge) checks
    always @(chk_ev) begin
        while (q.size() > 0 && q[0].due < 0) check_front();
    end

    task automatic push_exp(input bit which, input string nm, input int pc,
                            input logic r, input logic d, input int cc);
        exp_t e;
        e.due = cyc + 1; e.which = which; e.pc = 10'(pc);
        e.run = r; e.done = d; e.cct = 16'(cc);
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic push_now(input bit which, input string nm, input int pc,
                            input logic r, input logic d, input int cc);
        exp_t e;
        e.due = -1; e.which = which; e.pc = 10'(pc);
        e.run = r; e.done = d; e.cct = 16'(cc);
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic drive(input logic st, input logic [1:0] sel, input logic br,
                         input logic tk, input logic [9:0] tgt, input logic ak);
        @(negedge Clk);
        Start = st; ProgSel = sel; BranchEn = br; Taken = tk; Target = tgt; Ack = ak;
    endtask

    initial begin
        #2;
        push_now(0, "reset", 0, 0, 0, 0);
        ->chk_ev;
        @(negedge Clk);
        Reset = 1'b0;

        drive(1, 2'd1, 0, 0, 10'd0, 0);  push_exp(0, "start_p1", 256, 1, 0, 0);
                                          push_exp(1, "start_sat", 256, 1, 0, 0);
        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "seq1", 257, 1, 0, 1);
        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "seq2", 258, 1, 0, 2);
        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "seq3", 259, 1, 0, 3);
                                          push_exp(1, "seq3_sat", 259, 1, 0, 3);
        drive(0, 2'd0, 1, 1, 10'd300, 0); push_exp(0, "br_to300", 300, 1, 0, 4);
        drive(0, 2'd0, 1, 1, 10'd40, 0); push_exp(0, "br_taken", 40, 1, 0, 5);
        drive(0, 2'd0, 1, 1, 10'd300, 0); push_exp(0, "br_back", 300, 1, 0, 6);
        drive(0, 2'd0, 1, 0, 10'd40, 0); push_exp(0, "br_not_taken", 301, 1, 0, 7);
                                          push_exp(1, "sat_reach", 301, 1, 0, 7);
        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "seq_after_nt", 302, 1, 0, 8);
                                          push_exp(1, "sat_hold", 302, 1, 0, 7);
        drive(1, 2'd2, 0, 0, 10'd0, 0);  push_exp(0, "start_in_run", 303, 1, 0, 9);
                                          push_exp(1, "sat_hold2", 303, 1, 0, 7);
        drive(0, 2'd0, 1, 1, 10'd77, 0); push_exp(0, "br_to77", 77, 1, 0, 10);
        drive(0, 2'd0, 1, 1, 10'd5, 1);  push_exp(0, "ack_over_br", 77, 0, 1, 11);
        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "halt_hold", 77, 0, 1, 11);
        drive(1, 2'd3, 0, 0, 10'd0, 0);  push_exp(0, "halt_sel3", 77, 0, 1, 11);
        drive(1, 2'd2, 0, 0, 10'd0, 0);  push_exp(0, "restart_p2", 512, 1, 0, 0);
                                          push_exp(1, "restart_sat", 512, 1, 0, 0);
        drive(0, 2'd0, 1, 1, 10'd1023, 0); push_exp(0, "br_to1023", 1023, 1, 0, 1);
        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "pc_wrap", 0, 1, 0, 2);
        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "post_wrap", 1, 1, 0, 3);

        // Asynchronous reset between edges while running
        drive(0, 2'd0, 0, 0, 10'd0, 0);
        #3 Reset = 1'b1;
        #1;
        push_now(0, "async_rst", 0, 0, 0, 0);
        push_now(1, "async_rst_sat", 0, 0, 0, 0);
        ->chk_ev;
        @(negedge Clk);
        Reset = 1'b0;

        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "rst_idle", 0, 0, 0, 0);
        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "rst_idle2", 0, 0, 0, 0);
        drive(1, 2'd3, 0, 0, 10'd0, 0);  push_exp(0, "idle_sel3", 0, 0, 0, 0);
        drive(1, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "start_p0", 0, 1, 0, 0);
        drive(0, 2'd0, 0, 0, 10'd0, 0);  push_exp(0, "p0_seq", 1, 1, 0, 1);
        drive(0, 2'd0, 0, 0, 10'd0, 1);  push_exp(0, "p0_ack", 1, 0, 1, 2);
        drive(0, 2'd0, 0, 0, 10'd0, 0);

        repeat (3) @(negedge Clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of run, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
